// File: rtl/frog_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frog_game_ctrl
// Purpose  : Game-rule controller for a frog-crossing game. Detects frog
//            collisions with cars, logs, water, the screen edges and the home
//            row once per video frame. Sequences the game through idle, play,
//            death pause, level-clear pause and game-over. Keeps lives,
//            level, score and the per-attempt timer.
// Revision : 1.0 - initial release
// ============================================================================
module frog_game_ctrl #(
    parameter int CAR_LANES     = 6,
    parameter int LOG_LANES     = 6,
    parameter int LOGS_PER_LANE = 2,
    parameter int BLOCK         = 32,
    parameter int CAR_Y0        = 256,
    parameter int LOG_Y0        = 32,
    parameter int XMIN          = 96,
    parameter int XMAX          = 576,
    parameter int LIVES         = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int WIN_FRAMES    = 90,
    parameter int TIME_FRAMES   = 1800,
    parameter int SCORE_W       = 14
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   frame_tick,
    input  logic                                   start,
    input  logic [9:0]                             frog_x,
    input  logic [9:0]                             frog_y,
    input  logic [CAR_LANES*10-1:0]                car_x,
    input  logic [CAR_LANES*10-1:0]                car_len,
    input  logic [LOG_LANES*LOGS_PER_LANE*10-1:0]  log_x,
    input  logic [LOG_LANES*10-1:0]                log_len,
    output logic [2:0]                             state,
    output logic                                   frog_reset,
    output logic                                   freeze,
    output logic [$clog2(LIVES+1)-1:0]             lives,
    output logic [3:0]                             level,
    output logic [SCORE_W-1:0]                     score,
    output logic [$clog2(TIME_FRAMES+1)-1:0]       time_left,
    output logic [1:0]                             death_cause,
    output logic [LOG_LANES-1:0]                   on_log
);

    localparam int c_LW        = $clog2(LIVES + 1);
    localparam int c_TW        = $clog2(TIME_FRAMES + 1);
    localparam int c_PAUSE_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
    localparam int c_PW        = $clog2(c_PAUSE_MAX + 1);
    // Score sums carry 9 spare bits so that +250 can never wrap before saturation
    localparam int c_SW        = SCORE_W + 9;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_PLAY  = 3'd1;
    localparam logic [2:0] c_DYING = 3'd2;
    localparam logic [2:0] c_WIN   = 3'd3;
    localparam logic [2:0] c_OVER  = 3'd4;

    localparam logic [9:0]      c_ROW_START   = 10'd15;
    localparam logic [10:0]     c_BLK         = 11'(BLOCK);
    localparam logic [10:0]     c_RIVER_TOP   = 11'(LOG_Y0);
    localparam logic [10:0]     c_RIVER_BOT   = 11'(LOG_Y0 + LOG_LANES * BLOCK);
    localparam logic [10:0]     c_XMIN        = 11'(XMIN);
    localparam logic [10:0]     c_XMAX        = 11'(XMAX);
    localparam logic [c_SW-1:0] c_SCORE_MAX   = {{9{1'b0}}, {SCORE_W{1'b1}}};

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [2:0]         state_q,      state_d;
    logic [c_LW-1:0]    lives_q,      lives_d;
    logic [3:0]         level_q,      level_d;
    logic [SCORE_W-1:0] score_q,      score_d;
    logic [c_TW-1:0]    time_q,       time_d;
    logic [1:0]         cause_q,      cause_d;
    logic [c_PW-1:0]    pause_q,      pause_d;
    logic [9:0]         best_row_q,   best_row_d;
    logic               frog_reset_q, frog_reset_d;
    logic               start_q;

    // ------------------------------------------------------------------
    // Geometry: all compares in 11 bits so x+len never wraps
    // ------------------------------------------------------------------
    logic [10:0] w_fx, w_fy, w_fx_end, w_fy_end;
    assign w_fx     = {1'b0, frog_x};
    assign w_fy     = {1'b0, frog_y};
    assign w_fx_end = w_fx + c_BLK;
    assign w_fy_end = w_fy + c_BLK;

    logic [CAR_LANES-1:0] w_car_lane_hit;

    for (genvar i = 0; i < CAR_LANES; i++) begin : g_car
        localparam logic [10:0] c_LY = 11'(CAR_Y0 + i * BLOCK);
        logic [10:0] w_ox, w_oend;
        assign w_ox   = {1'b0, car_x[10*i +: 10]};
        assign w_oend = w_ox + {1'b0, car_len[10*i +: 10]};
        assign w_car_lane_hit[i] = (w_fx < w_oend) && (w_fx_end > w_ox) &&
                                   (w_fy < c_LY + c_BLK) && (w_fy_end > c_LY);
    end

    for (genvar i = 0; i < LOG_LANES; i++) begin : g_log_lane
        localparam logic [10:0] c_LY = 11'(LOG_Y0 + i * BLOCK);
        logic [10:0]              w_olen;
        logic [LOGS_PER_LANE-1:0] w_log_hit;
        assign w_olen = {1'b0, log_len[10*i +: 10]};
        for (genvar j = 0; j < LOGS_PER_LANE; j++) begin : g_log
            logic [10:0] w_ox;
            assign w_ox = {1'b0, log_x[10*(i*LOGS_PER_LANE+j) +: 10]};
            assign w_log_hit[j] = (w_fx < w_ox + w_olen) && (w_fx_end > w_ox) &&
                                  (w_fy < c_LY + c_BLK) && (w_fy_end > c_LY);
        end
        assign on_log[i] = |w_log_hit;
    end

    logic w_car_hit, w_water, w_offscreen, w_home, w_start_rise;
    assign w_car_hit    = |w_car_lane_hit;
    assign w_water      = (w_fy >= c_RIVER_TOP) && (w_fy < c_RIVER_BOT) && (on_log == '0);
    assign w_offscreen  = (w_fx_end <= c_XMIN) || (w_fx >= c_XMAX);
    assign w_home       = (w_fy < c_RIVER_TOP);
    assign w_start_rise = start && !start_q;

    logic [9:0] w_row;
    assign w_row = frog_y / 10'(BLOCK);

    // ------------------------------------------------------------------
    // Saturating score sums
    // ------------------------------------------------------------------
    logic [c_SW-1:0]    w_win_sum, w_step_sum;
    logic [SCORE_W-1:0] w_win_score, w_step_score;
    assign w_win_sum    = c_SW'(score_q) + c_SW'(100) + c_SW'(level_q) * c_SW'(10);
    assign w_step_sum   = c_SW'(score_q) + c_SW'(10);
    assign w_win_score  = (w_win_sum  > c_SCORE_MAX) ? {SCORE_W{1'b1}} : w_win_sum[SCORE_W-1:0];
    assign w_step_score = (w_step_sum > c_SCORE_MAX) ? {SCORE_W{1'b1}} : w_step_sum[SCORE_W-1:0];

    logic       w_die;
    logic [1:0] w_cause;

    // Death priority: car, water, offscreen, timeout
    always_comb begin
        w_die   = 1'b1;
        w_cause = 2'd0;
        if (w_car_hit)            w_cause = 2'd1;
        else if (w_water)         w_cause = 2'd2;
        else if (w_offscreen)     w_cause = 2'd3;
        else if (time_q == '0)    w_cause = 2'd0;
        else                      w_die   = 1'b0;
    end

    // State and game-register storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= c_IDLE;
            lives_q      <= '0;
            level_q      <= '0;
            score_q      <= '0;
            time_q       <= '0;
            cause_q      <= '0;
            pause_q      <= '0;
            best_row_q   <= c_ROW_START;
            frog_reset_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            score_q      <= score_d;
            time_q       <= time_d;
            cause_q      <= cause_d;
            pause_q      <= pause_d;
            best_row_q   <= best_row_d;
            frog_reset_q <= frog_reset_d;
            start_q      <= start;
        end
    end

    // Next-state and game-register update rules
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        score_d      = score_q;
        time_d       = time_q;
        cause_d      = cause_q;
        pause_d      = pause_q;
        best_row_d   = best_row_q;
        frog_reset_d = 1'b0;

        case (state_q)
            c_IDLE: begin
                // A start edge preempts any frame evaluation on the same cycle
                if (w_start_rise) begin
                    state_d      = c_PLAY;
                    lives_d      = c_LW'(LIVES);
                    level_d      = 4'd1;
                    score_d      = '0;
                    time_d       = c_TW'(TIME_FRAMES);
                    frog_reset_d = 1'b1;
                    best_row_d   = c_ROW_START;
                end
            end
            c_PLAY: begin
                if (frame_tick) begin
                    if (w_die) begin
                        state_d = c_DYING;
                        lives_d = (lives_q != '0) ? lives_q - 1'b1 : lives_q;
                        cause_d = w_cause;
                        pause_d = c_PW'(DEATH_FRAMES);
                    end else if (w_home) begin
                        // Reaching home earns only the level bonus, not a row step
                        state_d = c_WIN;
                        score_d = w_win_score;
                        pause_d = c_PW'(WIN_FRAMES);
                    end else begin
                        time_d = time_q - 1'b1;
                        if (w_row < best_row_q) begin
                            score_d    = w_step_score;
                            best_row_d = w_row;
                        end
                    end
                end
            end
            c_DYING: begin
                if (frame_tick) begin
                    if (pause_q == '0) begin
                        if (lives_q == '0) begin
                            state_d = c_OVER;
                        end else begin
                            state_d      = c_PLAY;
                            time_d       = c_TW'(TIME_FRAMES);
                            frog_reset_d = 1'b1;
                            best_row_d   = c_ROW_START;
                        end
                    end else begin
                        pause_d = pause_q - 1'b1;
                    end
                end
            end
            c_WIN: begin
                if (frame_tick) begin
                    if (pause_q == '0) begin
                        state_d      = c_PLAY;
                        level_d      = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                        time_d       = c_TW'(TIME_FRAMES);
                        frog_reset_d = 1'b1;
                        best_row_d   = c_ROW_START;
                    end else begin
                        pause_d = pause_q - 1'b1;
                    end
                end
            end
            c_OVER: begin
                // Score and level stay visible until the next game starts
                if (w_start_rise) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Frog input is enabled only while playing
    always_comb begin
        freeze = (state_q != c_PLAY);
    end

    assign state       = state_q;
    assign frog_reset  = frog_reset_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign score       = score_q;
    assign time_left   = time_q;
    assign death_cause = cause_q;

endmodule
`default_nettype wire
